// File: rtl/fifo_tick_reader.sv
// Read-side consumer for a standard (non-FWFT) byte FIFO: paced or free-running pops,
// valid/ready output stage, accepted-byte counter and incrementing-sequence checker.
module fifo_tick_reader #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter bit PACED     = 1'b1,
    parameter bit SEQ_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              pace_tick,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic              seq_err
);

    typedef enum logic [1:0] {IDLE, RD, HOLD} state_t;

    localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic                seq_err_q, seq_err_d;
    logic                seq_first_q, seq_first_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic                tick_pend_q, tick_pend_d;

    logic pend_eff;
    logic pop;
    logic accept;

    always_comb begin
        pend_eff = PACED ? tick_pend_q : 1'b1;
        // Gated by reset so the FIFO is never drained while the reader is held.
        pop      = (state_q == IDLE) && !fifo_empty && pend_eff && !reset;
        accept   = (state_q == HOLD) && out_valid_q && out_ready;

        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rd_count_d  = rd_count_q;
        seq_err_d   = seq_err_q;
        seq_first_d = seq_first_q;
        exp_d       = exp_q;
        tick_pend_d = 1'b0;

        // Tick set wins over pop clear; extra ticks merge into one pending pop.
        if (PACED) begin
            if (pace_tick)
                tick_pend_d = 1'b1;
            else if (pop)
                tick_pend_d = 1'b0;
            else
                tick_pend_d = tick_pend_q;
        end

        unique case (state_q)
            IDLE: if (pop) state_d = RD;
            RD: begin
                out_data_d  = fifo_dout;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: if (accept) begin
                out_valid_d = 1'b0;
                rd_count_d  = rd_count_q + ONE_C;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (SEQ_CHECK && accept) begin
            if (seq_first_q)
                seq_first_d = 1'b0;
            else if (out_data_q != exp_q)
                seq_err_d = 1'b1;
            exp_d = out_data_q + ONE_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rd_count_q  <= '0;
            seq_err_q   <= 1'b0;
            seq_first_q <= 1'b1;
            exp_q       <= '0;
            tick_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rd_count_q  <= rd_count_d;
            seq_err_q   <= seq_err_d;
            seq_first_q <= seq_first_d;
            exp_q       <= exp_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    assign fifo_rd_en = pop;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign rd_count   = rd_count_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_fifo_tick_reader.sv
// Bench for fifo_tick_reader: one paced and one unpaced instance, each fed by a FIFO model,
// with a scoreboard queue per instance checked by a monitor on every accepted byte.
module tb_fifo_tick_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- paced instance ----------------
    logic       reset_p = 1'b1, tick_p = 1'b0, ready_p = 1'b1;
    logic [7:0] dout_p = 8'h00, data_p;
    logic       empty_p, rd_en_p, valid_p, seq_err_p;
    logic [7:0] rd_count_p;
    logic [7:0] mem_p [64];
    int         wr_p = 0, rd_p = 0, rdcnt_p = 0;
    logic [7:0] exp_p [$];

    assign empty_p = (rd_p == wr_p);
    always @(posedge clk) if (rd_en_p && rd_p != wr_p) begin
        dout_p <= mem_p[rd_p];
        rd_p   <= rd_p + 1;
    end

    fifo_tick_reader #(.DATA_W(8), .CNT_W(8), .PACED(1'b1), .SEQ_CHECK(1'b1)) dut_p (
        .clk(clk), .reset(reset_p), .fifo_dout(dout_p), .fifo_empty(empty_p),
        .fifo_rd_en(rd_en_p), .pace_tick(tick_p), .out_data(data_p), .out_valid(valid_p),
        .out_ready(ready_p), .rd_count(rd_count_p), .seq_err(seq_err_p)
    );

    // ---------------- unpaced instance ----------------
    logic       reset_u = 1'b1, tick_u = 1'b0, ready_u = 1'b1;
    logic [7:0] dout_u = 8'h00, data_u;
    logic       empty_u, rd_en_u, valid_u, seq_err_u;
    logic [7:0] rd_count_u;
    logic [7:0] mem_u [64];
    int         wr_u = 0, rd_u = 0, rdcnt_u = 0;
    logic [7:0] exp_u [$];

    assign empty_u = (rd_u == wr_u);
    always @(posedge clk) if (rd_en_u && rd_u != wr_u) begin
        dout_u <= mem_u[rd_u];
        rd_u   <= rd_u + 1;
    end

    fifo_tick_reader #(.DATA_W(8), .CNT_W(8), .PACED(1'b0), .SEQ_CHECK(1'b1)) dut_u (
        .clk(clk), .reset(reset_u), .fifo_dout(dout_u), .fifo_empty(empty_u),
        .fifo_rd_en(rd_en_u), .pace_tick(tick_u), .out_data(data_u), .out_valid(valid_u),
        .out_ready(ready_u), .rd_count(rd_count_u), .seq_err(seq_err_u)
    );

    // ---------------- monitors ----------------
    int   last_rd_cyc_u = 0;
    logic prev_valid_u = 1'b0;

    always @(negedge clk) begin
        if (rd_en_p) begin
            rdcnt_p++;
            chk("p_rd_en_not_empty", 32'(empty_p), 32'd0);
        end
        if (valid_p && ready_p) begin
            if (exp_p.size() == 0) chk("p_unexpected_accept", 32'(data_p), 32'hFFFF_FFFF);
            else chk("p_accept_data", 32'(data_p), 32'(exp_p.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rd_en_u) begin
            rdcnt_u++;
            last_rd_cyc_u = cyc;
            chk("u_rd_en_not_empty", 32'(empty_u), 32'd0);
        end
        if (valid_u && !prev_valid_u)
            chk("u_valid_latency", 32'(cyc - last_rd_cyc_u), 32'd2);
        prev_valid_u = valid_u;
        if (valid_u && ready_u) begin
            if (exp_u.size() == 0) chk("u_unexpected_accept", 32'(data_u), 32'hFFFF_FFFF);
            else chk("u_accept_data", 32'(data_u), 32'(exp_u.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_p(input logic [7:0] b);
        mem_p[wr_p] = b;
        wr_p++;
        exp_p.push_back(b);
    endtask

    task automatic push_u(input logic [7:0] b);
        mem_u[wr_u] = b;
        wr_u++;
        exp_u.push_back(b);
    endtask

    task automatic pulse_tick_p();
        tick_p = 1'b1;
        step(1);
        tick_p = 1'b0;
    endtask

    int c0;

    initial begin
        // Reset hold with data already waiting in both FIFOs.
        push_p(8'h05); push_p(8'h06); push_p(8'h07);
        push_u(8'hFE); push_u(8'hFF); push_u(8'h00); push_u(8'h01);
        repeat (10) begin
            @(negedge clk);
            chk("rst_rd_en_p", 32'(rd_en_p), 32'd0);
            chk("rst_valid_p", 32'(valid_p), 32'd0);
            chk("rst_count_p", 32'(rd_count_p), 32'd0);
            chk("rst_seqerr_p", 32'(seq_err_p), 32'd0);
            chk("rst_rd_en_u", 32'(rd_en_u), 32'd0);
            chk("rst_valid_u", 32'(valid_u), 32'd0);
        end
        chk("rst_data_u", 32'(data_u), 32'd0);

        // Paced: one pop per tick, none once empty.
        step(1);
        reset_p = 1'b0;
        step(3);
        chk("p_no_pop_without_tick", 32'(rdcnt_p), 32'd0);
        for (int i = 0; i < 4; i++) begin
            c0 = rdcnt_p;
            pulse_tick_p();
            step(19);
            chk("p_pops_per_tick", 32'(rdcnt_p - c0), (i < 3) ? 32'd1 : 32'd0);
        end
        chk("p_count_3", 32'(rd_count_p), 32'd3);
        chk("p_seqerr_0", 32'(seq_err_p), 32'd0);

        // Unpaced: back-to-back across the 0xFF->0x00 wrap.
        reset_u = 1'b0;
        step(30);
        chk("u_count_4", 32'(rd_count_u), 32'd4);
        chk("u_seqerr_wrap", 32'(seq_err_u), 32'd0);

        // Backpressure: 0x10 held, 0x11 stays in FIFO.
        ready_u = 1'b0;
        push_u(8'h10); push_u(8'h11);
        step(6);
        c0 = rdcnt_u;
        repeat (15) begin
            @(negedge clk);
            chk("bp_data", 32'(data_u), 32'h10);
            chk("bp_valid", 32'(valid_u), 32'd1);
        end
        chk("bp_no_pop", 32'(rdcnt_u), 32'(c0));
        @(posedge clk); #1;
        ready_u = 1'b1;
        step(10);
        chk("bp_count_6", 32'(rd_count_u), 32'd6);
        chk("bp_seqerr_jump", 32'(seq_err_u), 32'd1);

        // Sequence break after fresh reset.
        reset_u = 1'b1;
        step(2);
        chk("u_rst_count", 32'(rd_count_u), 32'd0);
        chk("u_rst_seqerr", 32'(seq_err_u), 32'd0);
        chk("u_rst_valid", 32'(valid_u), 32'd0);
        reset_u = 1'b0;
        push_u(8'h01); push_u(8'h02);
        step(10);
        chk("seq_ok_01_02", 32'(seq_err_u), 32'd0);
        push_u(8'h04);
        step(8);
        chk("seq_err_04", 32'(seq_err_u), 32'd1);
        push_u(8'h05); push_u(8'h06);
        step(10);
        chk("seq_err_sticky", 32'(seq_err_u), 32'd1);
        chk("seq_count_5", 32'(rd_count_u), 32'd5);

        // Paced: the trailing tick from the empty-FIFO phase is still pending.
        ready_p = 1'b0;
        push_p(8'h08);
        step(6);
        chk("hold_valid_08", 32'(valid_p), 32'd1);
        chk("hold_data_08", 32'(data_p), 32'h08);
        c0 = rdcnt_p;
        repeat (3) begin
            pulse_tick_p();
            step(1);
        end
        push_p(8'h09); push_p(8'h0A);
        step(3);
        chk("hold_no_pop", 32'(rdcnt_p), 32'(c0));
        ready_p = 1'b1;
        step(15);
        chk("merged_ticks_one_pop", 32'(rdcnt_p), 32'(c0 + 1));
        chk("p_count_5", 32'(rd_count_p), 32'd5);
        chk("p_seqerr_still_0", 32'(seq_err_p), 32'd0);

        // Reset while 0x0A is held: discarded, not counted.
        ready_p = 1'b0;
        pulse_tick_p();
        step(5);
        chk("pre_rst_valid", 32'(valid_p), 32'd1);
        chk("pre_rst_data", 32'(data_p), 32'h0A);
        reset_p = 1'b1;
        step(1);
        reset_p = 1'b0;
        chk("mid_rst_valid", 32'(valid_p), 32'd0);
        chk("mid_rst_count", 32'(rd_count_p), 32'd0);
        void'(exp_p.pop_front());
        ready_p = 1'b1;
        step(10);
        chk("post_rst_no_pop", 32'(rdcnt_p), 32'(c0 + 2));
        chk("post_rst_valid", 32'(valid_p), 32'd0);

        chk("p_scoreboard_drained", 32'(exp_p.size()), 32'd0);
        chk("u_scoreboard_drained", 32'(exp_u.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
